softmax_row_ctrl: RTL and testbench
===================================

Name: softmax_row_ctrl

Overview:
Sequences the shared combinational exponential unit across one attention score row to produce softmax numerators.
- Buffers a row of ROW_LEN Q1.6 scores and finds the row max.
- Drives (score - max) through the exp unit one element per cycle and accumulates the row sum.
- Streams the exp values downstream over a credit-based interface; the downstream normaliser divides by row_sum.

Parameters:
ROW_LEN, 8, elements per row (≥2); buffer depth and index counter width derive from it.
CREDITS, 4, initial and maximum downstream credit count.
SUM_W, 12, row_sum width; must satisfy 2^SUM_W > ROW_LEN*255.

Ports:
clk  in  1  clock, all state on rising edge.
rst  in  1  asynchronous, active-high reset.
in_valid  in  1  score beat valid.
in_ready  out  1  controller accepts a beat.
in_data  in  8  signed Q1.6 score.
ex_operand  out  8  signed Q1.6 operand to the exp unit (combinational from state).
ex_result  in  8  exp unit result, treated as unsigned Q1.6, same cycle.
out_valid  out  1  registered pulse; one exp value emitted.
out_data  out  8  registered exp value.
out_last  out  1  high with the final beat of a row.
credit_return  in  1  downstream freed one slot.
row_sum  out  SUM_W  sum of the row's exp values; held until the next row completes.
row_sum_valid  out  1  one-cycle pulse, coincident with out_last.

Behaviour:
- Reset (async): state=LOAD, counters 0, max=-128, sum=0, credits=CREDITS. out_valid, out_last, row_sum_valid, out_data and row_sum are 0.
- LOAD:
  - in_ready=1.
  - Each handshake writes in_data to buf[idx] and updates max with a signed compare.
  - On the ROW_LEN-th handshake: go to EXP, idx=0.
- EXP:
  - in_ready=0.
  - ex_operand = sat8(buf[idx] - max): 9-bit signed subtract, clamped to -128 (range [-255,0] → [-128,0]).
  - Each cycle: buf[idx] <= ex_result; sum += zero-extended ex_result; idx++.
  - Takes exactly ROW_LEN cycles, then go to DRAIN, idx=0.
  - ex_operand is 0 outside EXP.
- DRAIN:
  - Each cycle with credits>0: out_valid=1, out_data=buf[idx], idx++, credits--.
  - If credits==0: no emit (out_valid=0) and idx holds.
  - On the final element: out_last=1, row_sum_valid=1, row_sum<=sum, sum cleared, max reset to -128, go to LOAD.
  - First LOAD acceptance is possible the next cycle.
- Credit counter:
  - credit_return and emit in the same cycle: count unchanged.
  - credit_return while count==CREDITS (and no emit): ignored, count saturates.
  - Credits persist across rows and are updated in every state.
- Row latency, last input handshake to first out_valid: ROW_LEN+1 cycles given credits.
- Mid-operation reset: the row is discarded, no partial output, credits restored to CREDITS.

Optional Feature:
SOFTMAX_CREDIT_CHECK_EN
- Defined: adds output credit_err (1 bit, reset 0). It is a sticky flag, set by credit_return while count==CREDITS without a simultaneous emit, and cleared only by rst.
- Undefined: no credit_err port; excess returns are silently ignored. All other behaviour is identical.

Test Plan:
- ROW_LEN=8, scores all 0x40; bench exp model returns 0x40 for operand 0 → every ex_operand=0x00; eight out_data=0x40; row_sum=512; out_last and row_sum_valid on beat 8.
- Scores {0x7F,0x80,0,0,0,0,0,0} → max=0x7F; operand for 0x80 saturates to 0x80 (not wrap); element 0 operand=0x00.
- CREDITS=4, no credit_return → exactly 4 out_valid pulses, then stall; return 1 credit → exactly one more beat; return 4 → row completes.
- Emit and credit_return in the same cycle with credits=1 → count stays 1, streaming continues unbroken.
- Assert rst in EXP at idx=3 → all outputs 0, no out_valid; a next clean row produces the correct row_sum.
- SOFTMAX_CREDIT_CHECK_EN defined: credit_return at full count in LOAD → credit_err=1 and stays 1 through a full row; without the macro the credit count simply stays at 4.

Source files
------------

// File: rtl/softmax_row_ctrl_if.sv
// Stream, exp-unit and credit signals of softmax_row_ctrl.
// The controller uses the slave modport; the surrounding environment uses the master modport.
interface softmax_row_ctrl_if #(
  parameter int SUM_W = 12
);
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_data;
  logic [7:0]       ex_operand;
  logic [7:0]       ex_result;
  logic             out_valid;
  logic [7:0]       out_data;
  logic             out_last;
  logic             credit_return;
  logic [SUM_W-1:0] row_sum;
  logic             row_sum_valid;

  modport slave (
    input  in_valid, in_data, ex_result, credit_return,
    output in_ready, ex_operand, out_valid, out_data, out_last, row_sum, row_sum_valid
  );

  modport master (
    output in_valid, in_data, ex_result, credit_return,
    input  in_ready, ex_operand, out_valid, out_data, out_last, row_sum, row_sum_valid
  );
endinterface

// File: rtl/softmax_row_ctrl.sv
// Softmax row controller: buffers a row, runs (score - max) through the shared exp unit, streams numerators on credits.
// Optional SOFTMAX_CREDIT_CHECK_EN adds a sticky credit_err output for credit returns arriving at full count.
module softmax_row_ctrl #(
  parameter int ROW_LEN = 8,
  parameter int CREDITS = 4,
  parameter int SUM_W   = 12
) (
  input  logic clk,
  input  logic rst,
`ifdef SOFTMAX_CREDIT_CHECK_EN
  output logic credit_err,
`endif
  softmax_row_ctrl_if.slave bus
);

  localparam int IDX_W = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
  localparam int CRD_W = $clog2(CREDITS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROW_LEN - 1);
  localparam logic [CRD_W-1:0] CRD_MAX  = CRD_W'(CREDITS);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_EXP   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Score never exceeds the max, so the difference lies in [-255,0]; clamp instead of wrapping.
  function automatic logic [7:0] sat8(input logic [7:0] a, input logic [7:0] m);
    logic signed [8:0] diff;
    diff = $signed({a[7], a}) - $signed({m[7], m});
    if (diff < -9'sd128) begin
      sat8 = 8'h80;
    end else begin
      sat8 = diff[7:0];
    end
  endfunction

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       max_q, max_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [CRD_W-1:0] crd_q, crd_d;
  logic [7:0]       buf_q [ROW_LEN];
  logic [7:0]       buf_d [ROW_LEN];
  logic             out_valid_q, out_valid_d;
  logic [7:0]       out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic [SUM_W-1:0] row_sum_q, row_sum_d;
  logic             row_sum_valid_q, row_sum_valid_d;
  logic             emit_s;
  logic             in_ready_s;
  logic [7:0]       ex_operand_s;

  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    max_d           = max_q;
    sum_d           = sum_q;
    buf_d           = buf_q;
    out_valid_d     = 1'b0;
    out_data_d      = out_data_q;
    out_last_d      = 1'b0;
    row_sum_d       = row_sum_q;
    row_sum_valid_d = 1'b0;
    emit_s          = 1'b0;
    in_ready_s      = 1'b0;
    ex_operand_s    = 8'h00;
    case (state_q)
      ST_LOAD: begin
        in_ready_s = 1'b1;
        if (bus.in_valid) begin
          buf_d[idx_q] = bus.in_data;
          if ($signed(bus.in_data) > $signed(max_q)) begin
            max_d = bus.in_data;
          end else begin
            max_d = max_q;
          end
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = ST_EXP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          idx_d = idx_q;
        end
      end
      ST_EXP: begin
        ex_operand_s = sat8(buf_q[idx_q], max_q);
        buf_d[idx_q] = bus.ex_result;
        sum_d        = sum_q + {{(SUM_W-8){1'b0}}, bus.ex_result};
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = ST_DRAIN;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_DRAIN: begin
        if (crd_q != '0) begin
          emit_s      = 1'b1;
          out_valid_d = 1'b1;
          out_data_d  = buf_q[idx_q];
          if (idx_q == LAST_IDX) begin
            out_last_d      = 1'b1;
            row_sum_valid_d = 1'b1;
            row_sum_d       = sum_q;
            sum_d           = '0;
            max_d           = 8'h80;
            idx_d           = '0;
            state_d         = ST_LOAD;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          idx_d = idx_q;
        end
      end
      default: begin
        state_d = ST_LOAD;
        idx_d   = '0;
      end
    endcase
  end

  // A return and an emit in the same cycle cancel; returns beyond the maximum are dropped.
  always_comb begin
    crd_d = crd_q;
    case ({emit_s, bus.credit_return})
      2'b10: crd_d = crd_q - CRD_W'(1);
      2'b01: begin
        if (crd_q == CRD_MAX) begin
          crd_d = crd_q;
        end else begin
          crd_d = crd_q + CRD_W'(1);
        end
      end
      default: crd_d = crd_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_LOAD;
      idx_q           <= '0;
      max_q           <= 8'h80;
      sum_q           <= '0;
      crd_q           <= CRD_MAX;
      out_valid_q     <= 1'b0;
      out_data_q      <= 8'h00;
      out_last_q      <= 1'b0;
      row_sum_q       <= '0;
      row_sum_valid_q <= 1'b0;
      for (int i = 0; i < ROW_LEN; i++) begin
        buf_q[i] <= 8'h00;
      end
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      max_q           <= max_d;
      sum_q           <= sum_d;
      crd_q           <= crd_d;
      out_valid_q     <= out_valid_d;
      out_data_q      <= out_data_d;
      out_last_q      <= out_last_d;
      row_sum_q       <= row_sum_d;
      row_sum_valid_q <= row_sum_valid_d;
      buf_q           <= buf_d;
    end
  end

`ifdef SOFTMAX_CREDIT_CHECK_EN
  logic err_q, err_d;

  always_comb begin
    if (bus.credit_return && !emit_s && (crd_q == CRD_MAX)) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign credit_err = err_q;
`endif

  assign bus.in_ready      = in_ready_s;
  assign bus.ex_operand    = ex_operand_s;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_data      = out_data_q;
  assign bus.out_last      = out_last_q;
  assign bus.row_sum       = row_sum_q;
  assign bus.row_sum_valid = row_sum_valid_q;

endmodule

// File: tb/tb_softmax_row_ctrl.sv
// Directed testbench for softmax_row_ctrl with a linear exp model (64 + op/2) and a beat recorder.
module tb_softmax_row_ctrl;
  localparam int ROW_LEN = 8;
  localparam int CREDITS = 4;
  localparam int SUM_W   = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic auto_credit = 1'b1;
  logic man_ret = 1'b0;
  always #5 clk = ~clk;

  softmax_row_ctrl_if #(.SUM_W(SUM_W)) bus ();

`ifdef SOFTMAX_CREDIT_CHECK_EN
  logic credit_err;
`endif

  softmax_row_ctrl #(.ROW_LEN(ROW_LEN), .CREDITS(CREDITS), .SUM_W(SUM_W)) dut (
    .clk(clk),
    .rst(rst),
`ifdef SOFTMAX_CREDIT_CHECK_EN
    .credit_err(credit_err),
`endif
    .bus(bus)
  );

  function automatic logic [7:0] exp_model(input logic [7:0] op);
    logic signed [8:0] half;
    half = $signed({op[7], op}) >>> 1;
    return 8'(9'sd64 + half);
  endfunction

  assign bus.ex_result     = exp_model(bus.ex_operand);
  assign bus.credit_return = auto_credit ? bus.out_valid : man_ret;

  typedef struct packed {
    logic [7:0]       data;
    logic             last;
    logic             rsv;
    logic [SUM_W-1:0] sum;
  } beat_t;

  beat_t      beats [$];
  int         rsv_pulses = 0;
  int         total = 0;
  int         bad = 0;
  logic [7:0] row [ROW_LEN];
  logic [7:0] ops [ROW_LEN];
  logic [7:0] exp_ops [ROW_LEN];
  logic [7:0] exp_data [ROW_LEN];
  logic       early_valid;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.out_valid) beats.push_back({bus.out_data, bus.out_last, bus.row_sum_valid, bus.row_sum});
      if (bus.row_sum_valid) rsv_pulses <= rsv_pulses + 1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1);
  end

  task automatic send_row();
    int guard;
    for (int i = 0; i < ROW_LEN; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = row[i];
      guard = 0;
      while (bus.in_ready !== 1'b1 && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      total++;
      if (guard >= 50) begin
        bad++;
        $display("FAIL load_ready got in_ready=%b want 1", bus.in_ready);
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
  endtask

  task automatic capture_ops();
    early_valid = 1'b0;
    for (int k = 0; k < ROW_LEN; k++) begin
      ops[k] = bus.ex_operand;
      if (bus.out_valid === 1'b1) early_valid = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic wait_beats(input int n, input int budget);
    int cnt;
    cnt = 0;
    while (beats.size() < n && cnt < budget) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total += 7;
    if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got %b want 1", bus.in_ready); end
    if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got %b want 0", bus.out_valid); end
    if (bus.out_last !== 1'b0) begin bad++; $display("FAIL rst_out_last got %b want 0", bus.out_last); end
    if (bus.row_sum_valid !== 1'b0) begin bad++; $display("FAIL rst_rsv got %b want 0", bus.row_sum_valid); end
    if (bus.out_data !== 8'h00) begin bad++; $display("FAIL rst_out_data got %h want 00", bus.out_data); end
    if (bus.row_sum !== 12'd0) begin bad++; $display("FAIL rst_row_sum got %0d want 0", bus.row_sum); end
    if (bus.ex_operand !== 8'h00) begin bad++; $display("FAIL rst_ex_operand got %h want 00", bus.ex_operand); end
`ifdef SOFTMAX_CREDIT_CHECK_EN
    total++;
    if (credit_err !== 1'b0) begin bad++; $display("FAIL rst_credit_err got %b want 0", credit_err); end
`endif
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_uniform_row();
    int rsv0;
    for (int i = 0; i < ROW_LEN; i++) row[i] = 8'h40;
    beats.delete();
    rsv0 = rsv_pulses;
    send_row();
    capture_ops();
    for (int k = 0; k < ROW_LEN; k++) begin
      total++;
      if (ops[k] !== 8'h00) begin bad++; $display("FAIL uni_operand[%0d] got %h want 00", k, ops[k]); end
    end
    total += 2;
    if (early_valid !== 1'b0) begin bad++; $display("FAIL uni_early_valid got %b want 0", early_valid); end
    @(negedge clk);
    if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL uni_latency got out_valid=%b want 1", bus.out_valid); end
    wait_beats(ROW_LEN, 50);
    repeat (4) @(negedge clk);
    total += 3;
    if (beats.size() != ROW_LEN) begin bad++; $display("FAIL uni_beats got %0d want %0d", beats.size(), ROW_LEN); end
    if (rsv_pulses - rsv0 != 1) begin bad++; $display("FAIL uni_rsv_pulses got %0d want 1", rsv_pulses - rsv0); end
    if (bus.row_sum !== 12'd512) begin bad++; $display("FAIL uni_row_sum_hold got %0d want 512", bus.row_sum); end
    for (int k = 0; k < beats.size() && k < ROW_LEN; k++) begin
      total += 3;
      if (beats[k].data !== 8'h40) begin bad++; $display("FAIL uni_data[%0d] got %h want 40", k, beats[k].data); end
      if (beats[k].last !== (k == ROW_LEN - 1)) begin bad++; $display("FAIL uni_last[%0d] got %b", k, beats[k].last); end
      if (beats[k].rsv !== (k == ROW_LEN - 1)) begin bad++; $display("FAIL uni_rsv[%0d] got %b", k, beats[k].rsv); end
    end
    if (beats.size() == ROW_LEN) begin
      total++;
      if (beats[ROW_LEN-1].sum !== 12'd512) begin bad++; $display("FAIL uni_sum got %0d want 512", beats[ROW_LEN-1].sum); end
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < ROW_LEN; i++) begin
      row[i]      = 8'h00;
      exp_ops[i]  = 8'h81;
      exp_data[i] = 8'h00;
    end
    row[0] = 8'h7F; row[1] = 8'h80;
    exp_ops[0] = 8'h00; exp_ops[1] = 8'h80;
    exp_data[0] = 8'h40;
    beats.delete();
    send_row();
    capture_ops();
    for (int k = 0; k < ROW_LEN; k++) begin
      total++;
      if (ops[k] !== exp_ops[k]) begin bad++; $display("FAIL sat_operand[%0d] got %h want %h", k, ops[k], exp_ops[k]); end
    end
    wait_beats(ROW_LEN, 50);
    repeat (4) @(negedge clk);
    total++;
    if (beats.size() != ROW_LEN) begin bad++; $display("FAIL sat_beats got %0d want %0d", beats.size(), ROW_LEN); end
    for (int k = 0; k < beats.size() && k < ROW_LEN; k++) begin
      total++;
      if (beats[k].data !== exp_data[k]) begin bad++; $display("FAIL sat_data[%0d] got %h want %h", k, beats[k].data, exp_data[k]); end
    end
    total++;
    if (bus.row_sum !== 12'd64) begin bad++; $display("FAIL sat_row_sum got %0d want 64", bus.row_sum); end
  endtask

  task automatic test_credit_stall();
    auto_credit = 1'b0;
    man_ret = 1'b0;
    for (int i = 0; i < ROW_LEN; i++) row[i] = 8'h40;
    beats.delete();
    send_row();
    capture_ops();
    repeat (20) @(negedge clk);
    total++;
    if (beats.size() != 4) begin bad++; $display("FAIL stall_first got %0d beats want 4", beats.size()); end
    man_ret = 1'b1;
    @(negedge clk);
    man_ret = 1'b0;
    repeat (10) @(negedge clk);
    total++;
    if (beats.size() != 5) begin bad++; $display("FAIL stall_one_more got %0d beats want 5", beats.size()); end
    man_ret = 1'b1;
    repeat (4) @(negedge clk);
    man_ret = 1'b0;
    repeat (10) @(negedge clk);
    total += 2;
    if (beats.size() != ROW_LEN) begin bad++; $display("FAIL stall_complete got %0d beats want %0d", beats.size(), ROW_LEN); end
    if (bus.row_sum !== 12'd512) begin bad++; $display("FAIL stall_row_sum got %0d want 512", bus.row_sum); end
    if (beats.size() == ROW_LEN) begin
      total += 2;
      if (beats[ROW_LEN-1].last !== 1'b1) begin bad++; $display("FAIL stall_last got %b want 1", beats[ROW_LEN-1].last); end
      if (beats[4].last !== 1'b0) begin bad++; $display("FAIL stall_early_last got %b want 0", beats[4].last); end
    end
  endtask

  task automatic test_credit_same_cycle();
    int run_cnt;
    for (int i = 0; i < ROW_LEN; i++) row[i] = 8'h40;
    beats.delete();
    send_row();
    capture_ops();
    man_ret = 1'b1;
    run_cnt = 0;
    for (int k = 0; k < ROW_LEN; k++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) run_cnt++;
    end
    man_ret = 1'b0;
    repeat (5) @(negedge clk);
    total += 2;
    if (run_cnt != ROW_LEN) begin bad++; $display("FAIL same_cycle_run got %0d consecutive want %0d", run_cnt, ROW_LEN); end
    if (beats.size() != ROW_LEN) begin bad++; $display("FAIL same_cycle_beats got %0d want %0d", beats.size(), ROW_LEN); end
    man_ret = 1'b1;
    repeat (3) @(negedge clk);
    man_ret = 1'b0;
    auto_credit = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mid_reset();
    auto_credit = 1'b1;
    for (int i = 0; i < ROW_LEN; i++) row[i] = 8'h40;
    beats.delete();
    send_row();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    total += 7;
    if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL mrst_out_valid got %b want 0", bus.out_valid); end
    if (bus.out_last !== 1'b0) begin bad++; $display("FAIL mrst_out_last got %b want 0", bus.out_last); end
    if (bus.row_sum_valid !== 1'b0) begin bad++; $display("FAIL mrst_rsv got %b want 0", bus.row_sum_valid); end
    if (bus.out_data !== 8'h00) begin bad++; $display("FAIL mrst_out_data got %h want 00", bus.out_data); end
    if (bus.row_sum !== 12'd0) begin bad++; $display("FAIL mrst_row_sum got %0d want 0", bus.row_sum); end
    if (bus.ex_operand !== 8'h00) begin bad++; $display("FAIL mrst_ex_operand got %h want 00", bus.ex_operand); end
    if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL mrst_in_ready got %b want 1", bus.in_ready); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    total++;
    if (beats.size() != 0) begin bad++; $display("FAIL mrst_no_output got %0d beats want 0", beats.size()); end
    row[0] = 8'h40; row[1] = 8'h20; row[2] = 8'h40;
    for (int i = 3; i < ROW_LEN; i++) row[i] = 8'h00;
    exp_data[0] = 8'd64; exp_data[1] = 8'd48; exp_data[2] = 8'd64;
    for (int i = 3; i < ROW_LEN; i++) exp_data[i] = 8'd32;
    beats.delete();
    send_row();
    capture_ops();
    wait_beats(ROW_LEN, 50);
    repeat (5) @(negedge clk);
    total += 2;
    if (beats.size() != ROW_LEN) begin bad++; $display("FAIL mrst_clean_beats got %0d want %0d", beats.size(), ROW_LEN); end
    if (bus.row_sum !== 12'd336) begin bad++; $display("FAIL mrst_clean_sum got %0d want 336", bus.row_sum); end
    for (int k = 0; k < beats.size() && k < ROW_LEN; k++) begin
      total++;
      if (beats[k].data !== exp_data[k]) begin bad++; $display("FAIL mrst_data[%0d] got %0d want %0d", k, beats[k].data, exp_data[k]); end
    end
  endtask

  task automatic test_credit_overflow();
    auto_credit = 1'b0;
    man_ret = 1'b1;
    repeat (3) @(negedge clk);
    man_ret = 1'b0;
    @(negedge clk);
`ifdef SOFTMAX_CREDIT_CHECK_EN
    total++;
    if (credit_err !== 1'b1) begin bad++; $display("FAIL ovf_err_set got %b want 1", credit_err); end
`endif
    for (int i = 0; i < ROW_LEN; i++) row[i] = 8'h40;
    beats.delete();
    send_row();
    capture_ops();
    repeat (20) @(negedge clk);
    total++;
    if (beats.size() != 4) begin bad++; $display("FAIL ovf_saturated got %0d beats want 4", beats.size()); end
    man_ret = 1'b1;
    repeat (4) @(negedge clk);
    man_ret = 1'b0;
    repeat (10) @(negedge clk);
    total++;
    if (beats.size() != ROW_LEN) begin bad++; $display("FAIL ovf_complete got %0d beats want %0d", beats.size(), ROW_LEN); end
`ifdef SOFTMAX_CREDIT_CHECK_EN
    total++;
    if (credit_err !== 1'b1) begin bad++; $display("FAIL ovf_err_sticky got %b want 1", credit_err); end
`endif
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    test_reset();
    test_uniform_row();
    test_saturation();
    test_credit_stall();
    test_credit_same_cycle();
    test_mid_reset();
    test_credit_overflow();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
